// File: rtl/ir_pkg.sv
// Shared types and constants for the IR remote display unit.
package ir_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BITS,
        S_GAP
    } ir_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Hex glyphs, gfedcba active-high; element n is the glyph for digit n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/ir_frame_rx.sv
// IR frame receiver: synchroniser, pulse-width measurement, frame FSM and parity check.
module ir_frame_rx
    import ir_pkg::*;
#(
    parameter int unsigned DATA_BITS = 4,
    parameter int unsigned PARITY_EN = 1,
    parameter int unsigned START_MIN = 80,
    parameter int unsigned START_MAX = 120,
    parameter int unsigned BIT_MIN   = 3,
    parameter int unsigned ONE_MIN   = 12,
    parameter int unsigned BIT_MAX   = 30,
    parameter int unsigned GAP_MAX   = 50
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ir,
    output logic [DATA_BITS-1:0] code_c,
    output logic                 valid_c,
    output logic                 err_c
);

    localparam int unsigned NB  = DATA_BITS + PARITY_EN;
    localparam int unsigned SAT = ((START_MAX > GAP_MAX) ? START_MAX : GAP_MAX) + 1;
    localparam int unsigned CW  = $clog2(SAT + 1);
    localparam int unsigned IW  = $clog2(NB + 1);

    logic          ir_m, ir_s, ir_q;
    logic          rise, fall;
    logic [CW-1:0] cnt;
    ir_state_e     state, state_d;
    logic [IW-1:0] idx, idx_d;
    logic [NB-1:0] sr, sr_d, full;
    logic [NB:0]   shifted;
    logic          bit_val;

    assign rise = ir_s & ~ir_q;
    assign fall = ir_q & ~ir_s;

    // Synchroniser and edge history; reset to the idle-high level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_m <= 1'b1;
            ir_s <= 1'b1;
            ir_q <= 1'b1;
        end else begin
            ir_m <= ir;
            ir_s <= ir_m;
            ir_q <= ir_s;
        end
    end

    // cnt holds the cycles spent at the current level before this one, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (rise || fall) begin
            cnt <= CW'(1);
        end else if (cnt != CW'(SAT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            sr    <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            sr    <= sr_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        sr_d    = sr;
        valid_c = 1'b0;
        err_c   = 1'b0;
        bit_val = (cnt >= CW'(ONE_MIN));
        shifted = {bit_val, sr};
        full    = shifted[NB:1];
        code_c  = full[DATA_BITS-1:0];
        case (state)
            S_IDLE: begin
                if (fall) state_d = S_START;
            end
            S_START: begin
                if (rise) begin
                    if (cnt >= CW'(START_MIN) && cnt <= CW'(START_MAX)) begin
                        state_d = S_GAP;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_BITS: begin
                if (cnt > CW'(BIT_MAX)) begin
                    state_d = S_IDLE;
                    err_c   = 1'b1;
                end else if (rise) begin
                    if (cnt < CW'(BIT_MIN)) begin
                        state_d = S_IDLE;
                        err_c   = 1'b1;
                    end else begin
                        sr_d = full;
                        if (idx == IW'(NB - 1)) begin
                            state_d = S_IDLE;
                            if ((PARITY_EN != 0) && (^full)) err_c = 1'b1;
                            else                             valid_c = 1'b1;
                        end else begin
                            idx_d   = idx + IW'(1);
                            state_d = S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                if (cnt > CW'(GAP_MAX)) begin
                    state_d = S_IDLE;
                    err_c   = 1'b1;
                end else if (fall) begin
                    state_d = S_BITS;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: rtl/ir_remote_display_unit.sv
// IR remote display unit: decoded code history, idle blanking and seven-segment drive.
module ir_remote_display_unit
    import ir_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 4,
    parameter int unsigned PARITY_EN   = 1,
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned START_MIN   = 80,
    parameter int unsigned START_MAX   = 120,
    parameter int unsigned BIT_MIN     = 3,
    parameter int unsigned ONE_MIN     = 12,
    parameter int unsigned BIT_MAX     = 30,
    parameter int unsigned GAP_MAX     = 50,
    parameter int unsigned HOLD_CYCLES = 30000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  IR,
    output logic                  code_valid,
    output logic                  frame_err,
    output logic [DATA_BITS-1:0]  last_code,
    output logic [7*DIGITS-1:0]   segments
);

    localparam int unsigned TW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    logic [DATA_BITS-1:0]   rx_code;
    logic                   rx_valid, rx_err;
    logic [DIGITS-1:0][3:0] hist, hist_d;
    logic [DIGITS-1:0]      hvld, hvld_d;
    logic                   disp_on, disp_on_d;
    logic [TW-1:0]          tmr, tmr_d;
    logic [DIGITS-1:0][6:0] seg_d;

    ir_frame_rx #(
        .DATA_BITS (DATA_BITS),
        .PARITY_EN (PARITY_EN),
        .START_MIN (START_MIN),
        .START_MAX (START_MAX),
        .BIT_MIN   (BIT_MIN),
        .ONE_MIN   (ONE_MIN),
        .BIT_MAX   (BIT_MAX),
        .GAP_MAX   (GAP_MAX)
    ) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .ir      (IR),
        .code_c  (rx_code),
        .valid_c (rx_valid),
        .err_c   (rx_err)
    );

    // A new code takes priority over a timeout expiring in the same cycle.
    always_comb begin
        hist_d    = hist;
        hvld_d    = hvld;
        disp_on_d = disp_on;
        tmr_d     = tmr;
        if (rx_valid) begin
            for (int k = int'(DIGITS) - 1; k > 0; k--) begin
                hist_d[k] = hist[k-1];
                hvld_d[k] = hvld[k-1];
            end
            hist_d[0] = 4'(rx_code);
            hvld_d[0] = 1'b1;
            disp_on_d = 1'b1;
            tmr_d     = TW'(HOLD_CYCLES);
        end else if ((HOLD_CYCLES != 0) && (tmr != '0)) begin
            tmr_d = tmr - TW'(1);
            if (tmr == TW'(1)) disp_on_d = 1'b0;
        end
        for (int k = 0; k < int'(DIGITS); k++) begin
            seg_d[k] = (disp_on_d && hvld_d[k]) ? HEX_SEG[hist_d[k]] : SEG_BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist       <= '0;
            hvld       <= '0;
            disp_on    <= 1'b0;
            tmr        <= '0;
            segments   <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            last_code  <= '0;
        end else begin
            hist       <= hist_d;
            hvld       <= hvld_d;
            disp_on    <= disp_on_d;
            tmr        <= tmr_d;
            segments   <= seg_d;
            code_valid <= rx_valid;
            frame_err  <= rx_err;
            if (rx_valid) last_code <= rx_code;
        end
    end

endmodule

// File: tb/tb_ir_remote_display_unit.sv
// Self-checking bench: directed frame table, timing corner sequences and random frames vs. a code-level model.
module tb_ir_remote_display_unit;

    localparam int NVEC = 13;
    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct packed {
        logic [7:0]      start_w;
        logic [4:0][7:0] w;
        logic [7:0]      gap;
        logic            exp_v;
        logic            exp_e;
        logic [3:0]      exp_code;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ir;
    logic        cv, fe, h_cv, h_fe;
    logic [3:0]  lc, h_lc;
    logic [27:0] seg, h_seg;

    int n_chk = 0, n_pass = 0;
    int nv = 0, ne = 0, nboth = 0;
    int hist_q[$];
    logic [3:0] exp_last;
    vec_t tbl [NVEC];

    always #5 clk = ~clk;

    ir_remote_display_unit u_dut (
        .clk (clk), .rst_n (rst_n), .IR (ir),
        .code_valid (cv), .frame_err (fe), .last_code (lc), .segments (seg)
    );

    ir_remote_display_unit #(.HOLD_CYCLES (100)) u_hold (
        .clk (clk), .rst_n (rst_n), .IR (ir),
        .code_valid (h_cv), .frame_err (h_fe), .last_code (h_lc), .segments (h_seg)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (cv) nv++;
            if (fe) ne++;
            if (cv && fe) nboth++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [27:0] exp_seg(input bit on);
        logic [27:0] s;
        s = '0;
        for (int k = 0; k < 4; k++)
            if (on && k < hist_q.size()) s[7*k +: 7] = GLYPH[hist_q[k]];
        return s;
    endfunction

    task automatic model_accept(input int code);
        hist_q.push_front(code);
        if (hist_q.size() > 4) void'(hist_q.pop_back());
        exp_last = 4'(code);
    endtask

    function automatic vec_t mk(input int sw, input int a, input int b, input int c, input int d,
                                input int e, input int gap, input bit v, input bit er, input int code);
        vec_t t;
        t.start_w  = 8'(sw);
        t.w[0] = 8'(a); t.w[1] = 8'(b); t.w[2] = 8'(c); t.w[3] = 8'(d); t.w[4] = 8'(e);
        t.gap      = 8'(gap);
        t.exp_v    = v;
        t.exp_e    = er;
        t.exp_code = 4'(code);
        return t;
    endfunction

    task automatic drive(input logic v, input int n);
        ir = v;
        repeat (n) @(negedge clk);
    endtask

    // Leaves IR high at the final rising edge.
    task automatic send_body(input int sw, input logic [4:0][7:0] w, input int gap);
        drive(1'b0, sw);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, gap);
            drive(1'b0, int'(w[i]));
        end
        ir = 1'b1;
    endtask

    function automatic int bit_w(input bit b);
        return b ? int'($urandom_range(30, 12)) : int'($urandom_range(11, 3));
    endfunction

    initial begin
        int lat, at, k;
        logic [4:0][7:0] w;
        // data widths: 20 = one, 6 = zero; last entry of each row is the parity bit
        tbl[0]  = mk(100, 20,  6, 20, 20, 20, 10, 1, 0, 4'hD);
        tbl[1]  = mk(100, 20,  6,  6,  6, 20, 10, 1, 0, 4'h1);
        tbl[2]  = mk(100,  6, 20,  6,  6, 20, 10, 1, 0, 4'h2);
        tbl[3]  = mk(100, 20, 20,  6,  6,  6, 10, 1, 0, 4'h3);
        tbl[4]  = mk(100, 20, 20, 20,  6, 20, 10, 1, 0, 4'h7);
        tbl[5]  = mk(150, 20,  6, 20, 20, 20, 10, 0, 0, 0);
        tbl[6]  = mk(100, 20,  6, 20, 20,  6, 10, 0, 1, 0);
        tbl[7]  = mk( 79, 20,  6, 20, 20, 20, 10, 0, 0, 0);
        tbl[8]  = mk( 80, 12, 11, 30,  3,  3, 50, 1, 0, 4'h5);
        tbl[9]  = mk(120, 11, 12,  3, 30,  3,  2, 1, 0, 4'hA);
        tbl[10] = mk(100, 20,  2, 20, 20, 20, 10, 0, 1, 0);
        tbl[11] = mk(100, 20, 31, 20, 20, 20, 10, 0, 1, 0);
        tbl[12] = mk(100, 20, 20, 20, 20,  6, 10, 1, 0, 4'hF);

        exp_last = '0;
        ir = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", 64'({cv, fe, lc, seg}), 64'(0));
        check("reset hold seg", 64'(h_seg), 64'(0));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            nv = 0; ne = 0;
            send_body(int'(tbl[i].start_w), tbl[i].w, int'(tbl[i].gap));
            drive(1'b1, 30);
            if (tbl[i].exp_v) model_accept(int'(tbl[i].exp_code));
            check($sformatf("vec%0d valid", i), 64'(nv), 64'(tbl[i].exp_v));
            check($sformatf("vec%0d err", i),   64'(ne), 64'(tbl[i].exp_e));
            check($sformatf("vec%0d last", i),  64'(lc), 64'(exp_last));
            check($sformatf("vec%0d seg", i),   64'(seg), 64'(exp_seg(1)));
        end

        // pin rise to code_valid latency
        w = {8'd6, 8'd6, 8'd20, 8'd20, 8'd6};
        send_body(100, w, 10);
        lat = 0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (cv && lat == 0) lat = j;
        end
        model_accept(6);
        check("latency", 64'(lat), 64'(3));
        drive(1'b1, 20);
        check("latency seg", 64'(seg), 64'(exp_seg(1)));

        // gap overflow after two bits
        nv = 0; ne = 0;
        drive(1'b0, 100); drive(1'b1, 10); drive(1'b0, 20); drive(1'b1, 10); drive(1'b0, 20);
        ir = 1'b1;
        at = 0;
        for (int j = 1; j <= 70; j++) begin
            @(negedge clk);
            if (fe && at == 0) at = j;
        end
        check("gap err time", 64'(at), 64'(54));
        check("gap err count", 64'(ne), 64'(1));
        check("gap no valid", 64'(nv), 64'(0));
        check("gap seg", 64'(seg), 64'(exp_seg(1)));

        // random frames against the code-level model
        for (int i = 0; i < 20; i++) begin
            int code;
            bit bad;
            code = int'($urandom_range(15, 0));
            bad  = ($urandom_range(4, 0) == 0);
            for (int b = 0; b < 4; b++) w[b] = 8'(bit_w(code[b]));
            w[4] = 8'(bit_w((^code[3:0]) ^ bad));
            nv = 0; ne = 0;
            send_body(int'($urandom_range(120, 80)), w, int'($urandom_range(50, 2)));
            drive(1'b1, 30);
            if (!bad) model_accept(code);
            check($sformatf("rnd%0d valid", i), 64'(nv), 64'(!bad));
            check($sformatf("rnd%0d err", i),   64'(ne), 64'(bad));
            check($sformatf("rnd%0d last", i),  64'(lc), 64'(exp_last));
            check($sformatf("rnd%0d seg", i),   64'(seg), 64'(exp_seg(1)));
        end

        // idle blanking on the short-hold instance
        w = {8'd6, 8'd20, 8'd20, 8'd6, 8'd6};
        send_body(100, w, 10);
        k = 0;
        while (!h_cv && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("hold code seen", 64'(h_cv), 64'(1));
        model_accept(12);
        repeat (99) @(negedge clk);
        check("hold still on", 64'(h_seg), 64'(exp_seg(1)));
        @(negedge clk);
        check("hold blank", 64'(h_seg), 64'(0));
        check("no-timeout seg", 64'(seg), 64'(exp_seg(1)));
        w = {8'd20, 8'd6, 8'd6, 8'd20, 8'd6};
        send_body(100, w, 10);
        drive(1'b1, 30);
        model_accept(2);
        check("hold reappear", 64'(h_seg), 64'(exp_seg(1)));

        // reset mid-frame
        drive(1'b0, 50);
        rst_n = 1'b0;
        #1;
        check("midreset outputs", 64'({cv, fe, lc, seg}), 64'(0));
        check("midreset hold seg", 64'(h_seg), 64'(0));
        hist_q.delete();
        exp_last = '0;
        ir = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        nv = 0; ne = 0;
        w = {8'd6, 8'd20, 8'd6, 8'd6, 8'd20};
        send_body(100, w, 10);
        drive(1'b1, 30);
        model_accept(9);
        check("post-reset valid", 64'(nv), 64'(1));
        check("post-reset last", 64'(lc), 64'(exp_last));
        check("post-reset seg", 64'(seg), 64'(exp_seg(1)));
        check("valid/err overlap", 64'(nboth), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ir_remote_display_unit.md
Name: ir_remote_display_unit

Overview:
- Parametrised successor to the single-digit IR remote functional unit.
- Decodes a pulse-width-coded remote-control frame from the raw IR receiver output, with frame validation and optional parity.
- Keeps a shift history of the last DIGITS received codes and drives DIGITS seven-segment displays, with optional blanking after an idle timeout.
- Sits between the IR receiver pin and the board seven-segment digits, clocked from the 10 kHz system tick clock.

Parameters:
- DATA_BITS, 4, number of code bits per frame (1..8); only the low 4 bits of each code are displayed.
- PARITY_EN, 1, 1 = one extra even-parity bit follows the data bits.
- DIGITS, 4, number of history entries and display digits (1..8).
- START_MIN, 80, minimum start-pulse low width in clk cycles.
- START_MAX, 120, maximum start-pulse low width.
- BIT_MIN, 3, minimum data-pulse low width; shorter is a glitch error.
- ONE_MIN, 12, a data-pulse low width of at least ONE_MIN decodes as 1; below it decodes as 0.
- BIT_MAX, 30, maximum data-pulse low width.
- GAP_MAX, 50, maximum high gap inside a frame.
- HOLD_CYCLES, 30000, idle cycles before the display blanks; 0 = hold forever.

Ports:
- clk  input  1  system clock (10 kHz)
- rst_n  input  1  asynchronous active-low reset
- IR  input  1  raw IR receiver output; idles high, low while carrier is present
- code_valid  output  1  one-cycle pulse when a good frame completes
- frame_err  output  1  one-cycle pulse when an in-progress frame is aborted
- last_code  output  DATA_BITS  most recent valid code
- segments  output  7*DIGITS  digit k at [7k+6:7k], gfedcba order, active-high; digit 0 = newest

Behaviour:
- Reset:
  - code_valid=0, frame_err=0, last_code=0, all segments=0 (blank).
  - History entries are empty; the FSM is in IDLE; counters are cleared.
  - Reset asserted mid-frame discards the partial frame; no pulses are emitted.
- Input conditioning:
  - 2-flop synchroniser to ir_s.
  - Rising and falling edges are detected on ir_s against its previous value.
  - The low-width counter and the gap counter saturate at max(START_MAX, GAP_MAX)+1.
- FSM states: IDLE, START, BITS, GAP.
  - IDLE: falling edge -> START, counter cleared.
  - START: rising edge with width in [START_MIN, START_MAX] -> GAP, bit index 0. Any other width -> IDLE, silently, with no frame_err (noise rejection).
  - BITS: rising edge with width < BIT_MIN or > BIT_MAX -> IDLE with frame_err. Otherwise shift the bit in, LSB first; if it was the final bit -> completion, else -> GAP. Low width exceeding BIT_MAX before a rising edge -> IDLE with frame_err, detected at count BIT_MAX+1.
  - GAP: falling edge -> BITS. High time > GAP_MAX -> IDLE with frame_err.
- Completion (final bit = DATA_BITS + PARITY_EN bits):
  - Parity error (XOR of data and parity bits = 1) -> frame_err, display unchanged.
  - Otherwise code_valid=1, last_code updated, history shifts (entry k <= entry k-1, entry 0 <= new code, oldest dropped), hold timer reloaded.
  - These effects are visible the cycle after the edge on which the final rising edge of ir_s is sampled.
  - Latency from the IR pin rising edge to code_valid is 3 cycles.
  - The FSM returns to IDLE on the same edge.
- Display:
  - Each non-empty history entry shows the hex glyph of its low 4 bits; empty entries show 0.
  - If HOLD_CYCLES>0 and no valid code arrives for HOLD_CYCLES cycles, all digits blank. History contents are retained and reappear shifted on the next valid code.
  - A timeout expiring in the same cycle as a new valid code: the new code wins, the display stays on, and the timer reloads.
- code_valid and frame_err are never both 1 in the same cycle.

Decomposition:
- Shared package ir_pkg:
  - state enum type;
  - 16-entry hex-to-segment constant table (0 -> 7'h3F, 1 -> 7'h06, … F -> 7'h71);
  - SEG_BLANK = 7'h00.
- One natural sub-module, ir_frame_rx: synchroniser, pulse measurement, FSM and parity.
  - Outputs: a code/valid/err triple.
- The top level holds the history registers, hold timer and segment mapping.

Test Plan:
- Start 100 low, then bits 1,0,1,1 (LSB first, widths 20/6/20/20), parity 1, gaps 10 -> code_valid once, last_code=4'hD, digit0=7'h5E, digits1-3=7'h00.
- Three further frames 1, 2, 3 after the first -> segments digits0-3 = 3,2,1,D glyphs; a fifth frame 7 drops D.
- Start 100, two bits, then IR high for 60 cycles -> frame_err one cycle at gap count 51, display unchanged.
- Start 150 low -> no pulses, FSM back in IDLE; a following valid frame decodes normally.
- Valid data with wrong parity -> frame_err, code_valid=0, history unchanged.
- HOLD_CYCLES=100: valid frame, then idle -> all digits 0 at cycle 100 after code_valid. rst_n pulsed low mid-frame -> all outputs 0 immediately, and the next frame decodes.
